// File: rtl/ifetch_if.sv
// Instruction fetch bus bundle.
// Groups the fetch unit's memory port, consumer handshake, redirect request and fault report.
//   im_addr/im_data              : combinational instruction memory port
//   out_valid/out_ready          : fetch queue head handshake
//   out_instr/out_pc             : fetch queue head payload
//   redirect_valid/redirect_pc   : branch/jump redirect request
//   fetch_fault/fault_pc         : sticky fault flag and captured PC
// modport master is the fetch unit side, modport slave the memory/consumer side.
interface ifetch_if;
  logic [31:0] im_addr;
  logic [31:0] im_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_fault;
  logic [31:0] fault_pc;

  modport master (
    output im_addr,
    input  im_data,
    output out_valid,
    input  out_ready,
    output out_instr,
    output out_pc,
    input  redirect_valid,
    input  redirect_pc,
    output fetch_fault,
    output fault_pc
  );

  modport slave (
    input  im_addr,
    output im_data,
    input  out_valid,
    output out_ready,
    input  out_instr,
    input  out_pc,
    output redirect_valid,
    output redirect_pc,
    input  fetch_fault,
    input  fault_pc
  );
endinterface

// File: rtl/ifetch_unit.sv
// Instruction fetch unit with a two-entry {pc, instr} queue.
// Fetches sequentially from a combinational instruction memory, one word per cycle, and hands
// words to the consumer through a valid/ready head. Redirects flush the queue and reload the PC.
// A misaligned or out-of-window PC stops fetching and raises a sticky fault until a redirect.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ifetch_if.master (memory port, queue head, redirect, fault report)
module ifetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter int unsigned IM_WORDS = 1024
) (
  input logic      clk,
  input logic      rst_n,
  ifetch_if.master bus
);

  typedef enum logic [0:0] {StRun, StFault} state_e;

  // 33-bit bounds so a window ending at 2^32 still compares correctly.
  localparam logic [32:0] WinLo = {1'b0, RESET_PC};
  localparam logic [32:0] WinHi = {1'b0, RESET_PC} + 33'(IM_WORDS) * 33'd4;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [1:0]  count_q, count_d;
  logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
  logic [31:0] ins0_q, ins0_d, ins1_q, ins1_d;
  logic [31:0] fault_pc_q, fault_pc_d;

  logic pc_ok;
  logic out_valid;
  logic pop;
  logic push;
  logic wr_slot1;

  assign pc_ok = (pc_q[1:0] == 2'b00) && ({1'b0, pc_q} >= WinLo) && ({1'b0, pc_q} < WinHi);

  assign out_valid = (count_q != 2'd0) && !bus.redirect_valid;
  assign pop       = out_valid && bus.out_ready;
  assign push      = (state_q == StRun) && !bus.redirect_valid && pc_ok &&
                     ((count_q != 2'd2) || pop);

  // Slot the new entry lands in once the head (if popped) has shifted out.
  assign wr_slot1 = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    count_d    = count_q;
    pc0_d      = pc0_q;
    pc1_d      = pc1_q;
    ins0_d     = ins0_q;
    ins1_d     = ins1_q;
    fault_pc_d = fault_pc_q;

    if (bus.redirect_valid) begin
      // Redirect wins over everything; fault_pc deliberately keeps its last value.
      state_d = StRun;
      pc_d    = bus.redirect_pc;
      count_d = 2'd0;
      pc0_d   = '0;
      pc1_d   = '0;
      ins0_d  = '0;
      ins1_d  = '0;
    end else begin
      if ((state_q == StRun) && !pc_ok) begin
        state_d    = StFault;
        fault_pc_d = pc_q;
      end

      if (pop) begin
        pc0_d  = pc1_q;
        ins0_d = ins1_q;
        pc1_d  = '0;
        ins1_d = '0;
      end

      if (push) begin
        pc_d = pc_q + 32'd4;
        if (wr_slot1) begin
          pc1_d  = pc_q;
          ins1_d = bus.im_data;
        end else begin
          pc0_d  = pc_q;
          ins0_d = bus.im_data;
        end
      end

      unique case ({push, pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StRun;
      pc_q       <= RESET_PC;
      count_q    <= 2'd0;
      pc0_q      <= '0;
      pc1_q      <= '0;
      ins0_q     <= '0;
      ins1_q     <= '0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      count_q    <= count_d;
      pc0_q      <= pc0_d;
      pc1_q      <= pc1_d;
      ins0_q     <= ins0_d;
      ins1_q     <= ins1_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  assign bus.im_addr     = pc_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_pc      = (count_q != 2'd0) ? pc0_q : 32'd0;
  assign bus.out_instr   = (count_q != 2'd0) ? ins0_q : 32'd0;
  assign bus.fetch_fault = (state_q == StFault);
  assign bus.fault_pc    = fault_pc_q;

endmodule
